data_bus_responder: RTL and testbench
=====================================

Name: data_bus_responder

Overview:
- Memory-side responder for the CPU's single-cycle data bus.
- Inputs: read/write strobes, 8-bit address, write data. Output: read data.
- Decodes the 8-bit address space into 240 bytes of data RAM plus a small bank of memory-mapped I/O registers.
- The I/O bank contains a TX byte FIFO with a valid/ready drain port, a prescaled free-running timer, and a GPIO register pair.

Parameters:
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..8
TIMER_DIV, 1, clock cycles per timer increment; 1..255

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
write  input  1  CPU write request
read  input  1  CPU read request
address  input  8  CPU read/write address
din  input  8  CPU write data (the CPU's dout)
dout  output  8  read data to CPU (the CPU's din)
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  sink accepts head byte this cycle
gpio_out  output  8  GPIO output register
gpio_in  input  8  GPIO input pins

Behaviour:
- Reset is asynchronous and active-high. While rst is high, all registers clear:
  - FIFO: empty, pointers = 0, overflow = 0.
  - Timer = 0, prescaler = 0, gpio_out = 0.
  - tx_valid = 0, tx_data = 0.
  - RAM contents are not reset and are undefined until written.
- Read path is combinational with no wait states.
  - dout = decoded value of address when read = 1; dout = 8'h00 when read = 0.
- Writes commit on the clk edge where write = 1.
- If read and write target the same address in the same cycle, dout returns the pre-write value.
- Address map:
  - 8'h00-8'hEF RAM: read returns the byte; write stores din.
  - 8'hF0 TX_DATA: write pushes din into the FIFO; read returns 0.
  - 8'hF1 STATUS: read = {1'b0, count[2:0], 1'b0, overflow, full, empty}. Writing with din[2] = 1 clears overflow; other bits are ignored.
  - 8'hF2 TIMER: read returns the current value. Write loads din into the timer and clears the prescaler.
  - 8'hF3 GPIO_OUT: read/write register driving gpio_out.
  - 8'hF4 GPIO_IN: read returns gpio_in, sampled through two flops (2-cycle latency); writes ignored.
  - 8'hF5-8'hFF: read 0; writes ignored.
- TX FIFO:
  - tx_valid = !empty; tx_data = head entry, registered storage output.
  - A pop occurs when tx_valid && tx_ready.
  - A push is accepted when !full, or when full with a pop in the same cycle (count unchanged).
  - A push while full with no pop is dropped and sets overflow (sticky).
  - Overflow clears only on a STATUS write or reset. If a clear and a new overflow coincide, set wins.
  - Simultaneous push and pop when empty: push accepted, no pop (tx_valid was 0).
  - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Timer:
  - The prescaler counts 0..TIMER_DIV-1. The timer increments when the prescaler wraps.
  - The timer wraps 8'hFF -> 8'h00 silently.
  - A CPU write to TIMER takes priority over an increment in the same cycle.
- Reset asserted mid-traffic discards FIFO contents immediately; tx_valid drops asynchronously.
- The block never stalls the CPU: no ready/wait output.

Test Plan:
- Reset, then write 8'h5A to 8'h10, then read 8'h10 -> dout = 8'h5A. Read 8'h10 with read = 0 -> dout = 8'h00.
- FIFO fill/overflow (FIFO_DEPTH = 4, tx_ready = 0):
  - Write 1,2,3,4 to 8'hF0 -> STATUS = 8'h42 (count 4, full).
  - Write 5 -> dropped; STATUS = 8'h46.
  - Write 8'h04 to STATUS -> 8'h42.
  - Raise tx_ready -> tx_data sequence 1,2,3,4, then tx_valid = 0 and STATUS = 8'h01.
- Full FIFO, tx_ready = 1 and a push of 8'hAA in the same cycle -> push accepted, count stays 4, no overflow; 8'hAA emerges last.
- Timer with TIMER_DIV = 3:
  - After reset, read TIMER at cycle 9 -> 3.
  - Load 8'hFE -> reads 8'hFF then 8'h00 at 3-cycle spacing.
  - A write coinciding with an increment edge -> loaded value wins.
- GPIO:
  - Write 8'hC3 to 8'hF3 -> gpio_out = 8'hC3 next cycle; read F3 -> 8'hC3.
  - Drive gpio_in = 8'h3C -> read F4 returns 8'h3C from the 2nd cycle after the change.
- Assert rst asynchronously with 3 FIFO entries and timer = 8'h20 -> tx_valid = 0, gpio_out = 0, timer = 0 before the next clk edge; STATUS = 8'h01 after release.

Source files
------------

// File: rtl/data_bus_if.sv
// CPU data-bus bundle between the CPU and the memory-side responder,
// including the TX drain port and GPIO pins that the responder exposes.
interface data_bus_if;
  logic       write;
  logic       read;
  logic [7:0] address;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] gpio_out;
  logic [7:0] gpio_in;

  // The master side is the CPU plus the external TX sink and GPIO pins.
  modport master (
    output write, read, address, din, tx_ready, gpio_in,
    input  dout, tx_data, tx_valid, gpio_out
  );

  modport slave (
    input  write, read, address, din, tx_ready, gpio_in,
    output dout, tx_data, tx_valid, gpio_out
  );
endinterface

// File: rtl/data_bus_responder.sv
// Single-cycle data-bus responder: 240-byte RAM plus an I/O bank with a TX
// byte FIFO, a prescaled free-running timer and a GPIO register pair.
module data_bus_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMER_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  data_bus_if.slave   bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int RAM_WORDS = 240;

  localparam logic [7:0] ADDR_TX_DATA  = 8'hF0;
  localparam logic [7:0] ADDR_STATUS   = 8'hF1;
  localparam logic [7:0] ADDR_TIMER    = 8'hF2;
  localparam logic [7:0] ADDR_GPIO_OUT = 8'hF3;
  localparam logic [7:0] ADDR_GPIO_IN  = 8'hF4;

  localparam logic [7:0]       DIV_LAST   = 8'(TIMER_DIV - 1);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  logic sel_ram;
  logic ram_wr;
  logic push;
  logic status_wr;
  logic timer_wr;
  logic gpio_wr;

  always_comb begin
    sel_ram   = (bus.address < ADDR_TX_DATA);
    ram_wr    = bus.write && sel_ram;
    push      = bus.write && (bus.address == ADDR_TX_DATA);
    status_wr = bus.write && (bus.address == ADDR_STATUS);
    timer_wr  = bus.write && (bus.address == ADDR_TIMER);
    gpio_wr   = bus.write && (bus.address == ADDR_GPIO_OUT);
  end

  // ------------------------------------------------------------------
  // Data RAM: no reset, combinational read so the CPU sees no wait state
  // ------------------------------------------------------------------
  logic [7:0] ram_mem [0:RAM_WORDS-1];

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      ram_mem[bus.address] <= bus.din;
    end
  end

  // ------------------------------------------------------------------
  // TX FIFO
  // ------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             overflow_reg;
  logic             overflow_next;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push_accept;
  logic [7:0]       fifo_word [0:FIFO_DEPTH-1];

  always_comb begin
    fifo_empty  = (count_reg == '0);
    fifo_full   = (count_reg == COUNT_FULL);
    pop         = !fifo_empty && bus.tx_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_accept = push && (!fifo_full || pop);
  end

  always_comb begin
    count_next = count_reg;
    case ({push_accept, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    overflow_next = overflow_reg;
    if (status_wr && bus.din[2]) begin
      overflow_next = 1'b0;
    end
    // A dropped push in the same cycle as a clear keeps the flag set.
    if (push && fifo_full && !pop) begin
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage entries are reset so the head output reads zero out of reset.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
      logic [7:0] entry_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= 8'h00;
        end else if (push_accept && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= bus.din;
        end
      end

      assign fifo_word[gi] = entry_reg;
    end
  endgenerate

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_word[rd_ptr_reg];

  // ------------------------------------------------------------------
  // Prescaled timer
  // ------------------------------------------------------------------
  logic [7:0] prescale_reg;
  logic [7:0] timer_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_reg <= 8'h00;
      timer_reg    <= 8'h00;
    end else if (timer_wr) begin
      prescale_reg <= 8'h00;
      timer_reg    <= bus.din;
    end else if (prescale_reg == DIV_LAST) begin
      prescale_reg <= 8'h00;
      timer_reg    <= timer_reg + 8'd1;
    end else begin
      prescale_reg <= prescale_reg + 8'd1;
    end
  end

  // ------------------------------------------------------------------
  // GPIO
  // ------------------------------------------------------------------
  logic [7:0] gpio_out_reg;
  logic [7:0] gpio_sync1_reg;
  logic [7:0] gpio_sync2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out_reg   <= 8'h00;
      gpio_sync1_reg <= 8'h00;
      gpio_sync2_reg <= 8'h00;
    end else begin
      if (gpio_wr) begin
        gpio_out_reg <= bus.din;
      end
      gpio_sync1_reg <= bus.gpio_in;
      gpio_sync2_reg <= gpio_sync1_reg;
    end
  end

  assign bus.gpio_out = gpio_out_reg;

  // ------------------------------------------------------------------
  // Read mux: reflects pre-edge state, so a same-address write is not seen
  // ------------------------------------------------------------------
  logic [2:0] count_lo;
  logic [7:0] status_value;
  logic [7:0] rd_value;

  always_comb begin
    count_lo     = 3'(count_reg);
    status_value = {1'b0, count_lo, 1'b0, overflow_reg, fifo_full, fifo_empty};
  end

  always_comb begin
    rd_value = 8'h00;
    if (sel_ram) begin
      rd_value = ram_mem[bus.address];
    end else begin
      case (bus.address)
        ADDR_STATUS:   rd_value = status_value;
        ADDR_TIMER:    rd_value = timer_reg;
        ADDR_GPIO_OUT: rd_value = gpio_out_reg;
        ADDR_GPIO_IN:  rd_value = gpio_sync2_reg;
        default:       rd_value = 8'h00;
      endcase
    end
  end

  assign bus.dout = bus.read ? rd_value : 8'h00;

endmodule

// File: tb/tb_data_bus_responder.sv
// Randomised and directed bench for data_bus_responder against a queue-based
// reference model of the address map, FIFO, timer and GPIO.
module tb_data_bus_responder;

  localparam int DEPTH = 4;
  localparam int DIV   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_bus_if bus ();

  data_bus_responder #(.FIFO_DEPTH(DEPTH), .TIMER_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] ram_m [0:239];
  logic [7:0] q_m [$];
  logic       ovf_m;
  logic [7:0] timer_base_m;
  int         timer_ticks_m;
  logic [7:0] gpio_out_m;
  logic [7:0] gpio_s1_m;
  logic [7:0] gpio_s2_m;
  logic [7:0] gpio_pins;

  assign bus.gpio_in = gpio_pins;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_timer();
    return 8'((int'(timer_base_m) + timer_ticks_m / DIV) % 256);
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    int n;
    n = q_m.size();
    if (a < 8'hF0) return ram_m[a];
    case (a)
      8'hF1:   return {1'b0, 3'(n), 1'b0, ovf_m, (n == DEPTH), (n == 0)};
      8'hF2:   return model_timer();
      8'hF3:   return gpio_out_m;
      8'hF4:   return gpio_s2_m;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    q_m.delete();
    ovf_m         = 1'b0;
    timer_base_m  = 8'h00;
    timer_ticks_m = 0;
    gpio_out_m    = 8'h00;
    gpio_s1_m     = 8'h00;
    gpio_s2_m     = 8'h00;
  endtask

  task automatic model_edge(input logic w, input logic [7:0] a, input logic [7:0] d,
                            input logic rdy);
    logic was_full;
    logic do_pop;
    was_full = (q_m.size() == DEPTH);
    do_pop   = (q_m.size() > 0) && rdy;
    if (do_pop) void'(q_m.pop_front());
    if (w && a == 8'hF1 && d[2]) ovf_m = 1'b0;
    if (w && a == 8'hF0) begin
      if (!was_full || do_pop) q_m.push_back(d);
      else ovf_m = 1'b1;
    end
    if (w && a < 8'hF0) ram_m[a] = d;
    if (w && a == 8'hF2) begin
      timer_base_m  = d;
      timer_ticks_m = 0;
    end else begin
      timer_ticks_m++;
    end
    if (w && a == 8'hF3) gpio_out_m = d;
    gpio_s2_m = gpio_s1_m;
    gpio_s1_m = gpio_pins;
  endtask

  // One bus cycle: drive, check outputs at the falling edge, advance model.
  task automatic step(input logic w, input logic r, input logic [7:0] a,
                      input logic [7:0] d, input logic rdy);
    bus.write    = w;
    bus.read     = r;
    bus.address  = a;
    bus.din      = d;
    bus.tx_ready = rdy;
    @(negedge clk);
    check("dout", bus.dout, r ? model_read(a) : 8'h00);
    check("tx_valid", 8'(bus.tx_valid), 8'(q_m.size() > 0));
    if (q_m.size() > 0) check("tx_data", bus.tx_data, q_m[0]);
    check("gpio_out", bus.gpio_out, gpio_out_m);
    $display("cyc w=%0b r=%0b a=%02h d=%02h rdy=%0b dout=%02h txv=%0b txd=%02h",
             w, r, a, d, rdy, bus.dout, bus.tx_valid, bus.tx_data);
    @(posedge clk);
    model_edge(w, a, d, rdy);
    #1;
  endtask

  // Combinational read without crossing a clock edge.
  task automatic probe(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus.write   = 1'b0;
    bus.read    = 1'b1;
    bus.address = a;
    #1;
    check(tag, bus.dout, exp);
    check({tag, "_model"}, exp, model_read(a));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] d;
    int sel;

    bus.write = 1'b0; bus.read = 1'b0; bus.address = 8'h00;
    bus.din = 8'h00; bus.tx_ready = 1'b0;
    gpio_pins = 8'h00;
    model_reset();

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_tx_valid", 8'(bus.tx_valid), 8'h00);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_gpio_out", bus.gpio_out, 8'h00);
    probe("rst_status", 8'hF1, 8'h01);
    probe("rst_timer", 8'hF2, 8'h00);

    // Timer from reset: 9 edges at divide-by-3
    idle(9);
    probe("timer_c9", 8'hF2, 8'h03);

    // RAM basic and read gating
    step(1'b1, 1'b0, 8'h10, 8'h5A, 1'b0);
    probe("ram_10", 8'h10, 8'h5A);
    bus.read = 1'b0;
    #1 check("ram_noread", bus.dout, 8'h00);

    // Fill RAM so every later read is defined
    for (int i = 0; i < 240; i++) step(1'b1, 1'b0, 8'(i), 8'($urandom), 1'b0);
    // Read and write same address: pre-write data returned
    step(1'b1, 1'b1, 8'h20, 8'hE7, 1'b0);
    probe("ram_rw_after", 8'h20, 8'hE7);

    // FIFO fill / overflow / clear / drain
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'hF0, 8'(i), 1'b0);
    probe("fifo_full", 8'hF1, 8'h42);
    step(1'b1, 1'b0, 8'hF0, 8'h05, 1'b0);
    probe("fifo_ovf", 8'hF1, 8'h46);
    step(1'b1, 1'b0, 8'hF1, 8'h04, 1'b0);
    probe("fifo_clr", 8'hF1, 8'h42);
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", bus.tx_data, 8'(i));
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    end
    check("drain_valid", 8'(bus.tx_valid), 8'h00);
    probe("drain_status", 8'hF1, 8'h01);

    // Full FIFO with simultaneous pop and push
    step(1'b1, 1'b0, 8'hF0, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'hF0, 8'h22, 1'b0);
    step(1'b1, 1'b0, 8'hF0, 8'h33, 1'b0);
    step(1'b1, 1'b0, 8'hF0, 8'h44, 1'b0);
    step(1'b1, 1'b0, 8'hF0, 8'hAA, 1'b1);
    probe("pushpop_status", 8'hF1, 8'h42);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    probe("pushpop_empty", 8'hF1, 8'h01);
    // Push and pop on an empty FIFO: push kept
    step(1'b1, 1'b0, 8'hF0, 8'h99, 1'b1);
    check("empty_pushpop", bus.tx_data, 8'h99);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Timer load and wrap
    step(1'b1, 1'b0, 8'hF2, 8'hFE, 1'b0);
    probe("timer_load", 8'hF2, 8'hFE);
    idle(3);
    probe("timer_ff", 8'hF2, 8'hFF);
    idle(3);
    probe("timer_wrap", 8'hF2, 8'h00);
    // Write on the increment edge: load wins
    step(1'b1, 1'b0, 8'hF2, 8'h10, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 8'hF2, 8'h77, 1'b0);
    probe("timer_prio", 8'hF2, 8'h77);

    // GPIO
    step(1'b1, 1'b0, 8'hF3, 8'hC3, 1'b0);
    check("gpio_out_c3", bus.gpio_out, 8'hC3);
    probe("gpio_rd", 8'hF3, 8'hC3);
    gpio_pins = 8'h3C;
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    probe("gpio_in_1", 8'hF4, 8'h00);
    step(1'b0, 1'b1, 8'hF4, 8'h00, 1'b0);
    probe("gpio_in_2", 8'hF4, 8'h3C);

    // Asynchronous reset mid-traffic
    step(1'b1, 1'b0, 8'hF0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'hF0, 8'h02, 1'b0);
    step(1'b1, 1'b0, 8'hF0, 8'h03, 1'b0);
    step(1'b1, 1'b0, 8'hF2, 8'h20, 1'b0);
    probe("pre_rst_timer", 8'hF2, 8'h20);
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_tx_valid", 8'(bus.tx_valid), 8'h00);
    check("arst_gpio_out", bus.gpio_out, 8'h00);
    probe("arst_timer", 8'hF2, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    probe("arst_status", 8'hF1, 8'h01);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: a = 8'($urandom_range(0, 239));
        3, 9:    a = 8'hF0;
        4:       a = 8'hF1;
        5:       a = 8'hF2;
        6:       a = 8'hF3;
        7:       a = 8'hF4;
        default: a = 8'($urandom_range(245, 255));
      endcase
      d = 8'($urandom);
      if ($urandom_range(0, 4) == 0) gpio_pins = 8'($urandom);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7), a, d,
           1'($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
